// File: rtl/branch_predictor_pkg.sv
// Shared CPU constants for the fetch-side branch predictor: word width,
// "no prediction" PC value, BTB defaults and 2-bit counter encodings.
package branch_predictor_pkg;

  localparam int unsigned WORD       = 32;
  // PC value driven when there is no usable prediction
  localparam logic [WORD-1:0] UNDEFINE = WORD'(0);

  localparam int unsigned BP_ENTRIES  = 16;
  localparam logic [1:0]  BP_CNT_INIT = 2'b10;

  // 2-bit saturating counter encodings; MSB set means "predict taken"
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-value function of a 2-bit saturating direction counter.
// Ports:
//   i_cnt    current counter value
//   i_taken  resolved direction (1 = taken)
//   o_cnt_c  next counter value (combinational), saturating at BP_SNT/BP_ST
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt_c
);

  // Step toward the resolved direction, holding at either end
  always_comb begin
    o_cnt_c = i_cnt;
    if (i_taken) begin
      if (i_cnt != BP_ST) o_cnt_c = i_cnt + 2'd1;
    end else begin
      if (i_cnt != BP_SNT) o_cnt_c = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters.
// Lookup is combinational on PC; training from EX resolutions is registered.
// Optional statistics counters are built when BP_STATS_EN is defined.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   PC                        IF-stage PC to look up
//   Pre_Branch, Pre_PC        prediction (redirect flag and target)
//   EX_Update                 branch resolved in EX this cycle
//   EX_Inst_PC, EX_Taken,
//   EX_Target, EX_Mispredict  resolution details
//   Stat_Lookups, Stat_Hits,
//   Stat_Mispred              (BP_STATS_EN only) 32-bit wrapping counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES  = BP_ENTRIES,
  parameter logic [1:0]  CNT_INIT = BP_CNT_INIT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [WORD-1:0] PC,
  output logic            Pre_Branch,
  output logic [WORD-1:0] Pre_PC,
  input  logic            EX_Update,
  input  logic [WORD-1:0] EX_Inst_PC,
  input  logic            EX_Taken,
  input  logic [WORD-1:0] EX_Target,
  input  logic            EX_Mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     Stat_Lookups,
  output logic [31:0]     Stat_Hits,
  output logic [31:0]     Stat_Mispred
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = WORD - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [1:0]       r_cnt    [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [WORD-1:0]  r_target [ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_u_cnt_nxt;
  logic             w_unused;

  // Lookup: reads pre-update contents, no write-to-read bypass
  assign w_idx      = PC[IDX_W+1:2];
  assign w_tag      = PC[WORD-1:IDX_W+2];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign Pre_Branch = w_hit && r_cnt[w_idx][1];
  assign Pre_PC     = w_hit ? r_target[w_idx] : UNDEFINE;

  // Update-side index/tag decode of the resolved branch
  assign w_u_idx = EX_Inst_PC[IDX_W+1:2];
  assign w_u_tag = EX_Inst_PC[WORD-1:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  branch_predictor_sat_counter2 u_sat_counter2 (
    .i_cnt   (r_cnt[w_u_idx]),
    .i_taken (EX_Taken),
    .o_cnt_c (w_u_cnt_nxt)
  );

  // Valid/counter state: trained on hits, allocated on taken misses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= BP_SNT;
      end
    end else if (EX_Update) begin
      if (w_u_hit) begin
        r_cnt[w_u_idx] <= w_u_cnt_nxt;
      end else if (EX_Taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_cnt[w_u_idx]   <= CNT_INIT;
      end
    end
  end

  // Tag/target payload: unreset, only meaningful behind a valid bit.
  // On a taken hit the tag rewrite is a no-op, so one write path covers
  // both retargeting and allocation.
  always_ff @(posedge clk) begin
    if (EX_Update && EX_Taken) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= EX_Target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_lookups;
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_mispred;

  // Free-running wrapping event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_lookups <= 32'd0;
      r_stat_hits    <= 32'd0;
      r_stat_mispred <= 32'd0;
    end else begin
      r_stat_lookups <= r_stat_lookups + 32'd1;
      if (w_hit) r_stat_hits <= r_stat_hits + 32'd1;
      if (EX_Update && EX_Mispredict) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign Stat_Lookups = r_stat_lookups;
  assign Stat_Hits    = r_stat_hits;
  assign Stat_Mispred = r_stat_mispred;
`endif

  // Byte-offset bits never participate; EX_Mispredict only feeds statistics
  assign w_unused = ^{PC[1:0], EX_Inst_PC[1:0], EX_Mispredict};

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (ENTRIES=16): reference model + scoreboard.
module tb_branch_predictor;

  typedef struct packed {
    logic        br;
    logic [31:0] pc;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [31:0] PC;
  logic        Pre_Branch;
  logic [31:0] Pre_PC;
  logic        EX_Update;
  logic [31:0] EX_Inst_PC;
  logic        EX_Taken;
  logic [31:0] EX_Target;
  logic        EX_Mispredict;
`ifdef BP_STATS_EN
  logic [31:0] Stat_Lookups;
  logic [31:0] Stat_Hits;
  logic [31:0] Stat_Mispred;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  // Reference model state
  logic        m_valid [16];
  logic [1:0]  m_cnt   [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];

  branch_predictor dut (
    .clk           (clk),
    .rstn          (rstn),
    .PC            (PC),
    .Pre_Branch    (Pre_Branch),
    .Pre_PC        (Pre_PC),
    .EX_Update     (EX_Update),
    .EX_Inst_PC    (EX_Inst_PC),
    .EX_Taken      (EX_Taken),
    .EX_Target     (EX_Target),
    .EX_Mispredict (EX_Mispredict)
`ifdef BP_STATS_EN
    ,
    .Stat_Lookups  (Stat_Lookups),
    .Stat_Hits     (Stat_Hits),
    .Stat_Mispred  (Stat_Mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    logic [3:0] idx;
    logic hit;
    idx  = pc[5:2];
    hit  = m_valid[idx] && (m_tag[idx] == pc[31:6]);
    e.br = hit && m_cnt[idx][1];
    e.pc = hit ? m_tgt[idx] : 32'h0;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 2'b00;
    end
  endtask

  task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    logic [3:0] idx;
    idx = pc[5:2];
    if (m_valid[idx] && m_tag[idx] == pc[31:6]) begin
      if (taken) begin
        if (m_cnt[idx] != 2'b11) m_cnt[idx] = m_cnt[idx] + 2'b01;
        m_tgt[idx] = tgt;
      end else if (m_cnt[idx] != 2'b00) begin
        m_cnt[idx] = m_cnt[idx] - 2'b01;
      end
    end else if (taken) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc[31:6];
      m_tgt[idx]   = tgt;
      m_cnt[idx]   = 2'b10;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", name, obs, expv);
      $error("%s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Push the model's expectation for the PC on the bus, then pop and compare
  task automatic score(input string name);
    exp_t e;
    sb_q.push_back(model_lookup(PC));
    #1;
    e = sb_q.pop_front();
    chk({name, ".br"}, {31'd0, Pre_Branch}, {31'd0, e.br});
    chk({name, ".pc"}, Pre_PC, e.pc);
  endtask

  task automatic lookup(input logic [31:0] pc, input string name);
    @(negedge clk);
    PC = pc;
    score(name);
  endtask

  // One-cycle EX update with a same-cycle lookup of look_pc (pre-update view)
  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic [31:0] look_pc, input string name);
    @(negedge clk);
    EX_Update     = 1'b1;
    EX_Inst_PC    = pc;
    EX_Taken      = taken;
    EX_Target     = tgt;
    EX_Mispredict = 1'b0;
    PC            = look_pc;
    score(name);
    @(posedge clk);
    model_update(pc, taken, tgt);
    #1;
    EX_Update = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; PC = 32'h1C000000;
    EX_Update = 1'b0; EX_Inst_PC = '0; EX_Taken = 1'b0; EX_Target = '0; EX_Mispredict = 1'b0;
    for (int i = 0; i < 16; i++) begin m_tag[i] = '0; m_tgt[i] = '0; end
    #2 rstn = 1'b0;
    model_reset();
    score("in_reset");
    #20 rstn = 1'b1;

    lookup(32'h1C000000, "post_reset");

    // Allocation; same-cycle lookup must still miss
    do_update(32'h1C000010, 1'b1, 32'h1C000040, 32'h1C000010, "alloc_same_cycle");
    lookup(32'h1C000010, "alloc_hit");

    // Decrement to 00, entry stays valid with target kept
    do_update(32'h1C000010, 1'b0, 32'h0, 32'h1C000010, "nt1_same");
    lookup(32'h1C000010, "nt1");
    do_update(32'h1C000010, 1'b0, 32'h0, 32'h1C000010, "nt2_same");
    lookup(32'h1C000010, "nt2_cnt00");
    do_update(32'h1C000010, 1'b0, 32'h0, 32'h1C000000, "nt3_floor");
    lookup(32'h1C000010, "floor_hold");

    // Climb to 11 then saturate; one NT afterwards must stay taken
    for (int k = 0; k < 4; k++) begin
      do_update(32'h1C000010, 1'b1, 32'h1C000040, 32'h1C000000, "tk_up");
      lookup(32'h1C000010, "tk_climb");
    end
    do_update(32'h1C000010, 1'b0, 32'h0, 32'h1C000000, "nt_after_sat");
    lookup(32'h1C000010, "no_wrap");

    // Alias: same index, different tag evicts the occupant
    do_update(32'h1C000050, 1'b1, 32'h1C000080, 32'h1C000050, "alias_same");
    lookup(32'h1C000010, "alias_old");
    lookup(32'h1C000050, "alias_new");

    // Not-taken miss never allocates
    do_update(32'h1C000020, 1'b0, 32'h1C000999, 32'h1C000020, "nt_miss_same");
    lookup(32'h1C000020, "nt_miss");

    // Taken hit retargets
    do_update(32'h1C000050, 1'b1, 32'h1C000100, 32'h1C000050, "retarget_same");
    lookup(32'h1C000050, "retarget");

    // EX_Update low: no state change even with taken data present
    @(negedge clk);
    EX_Inst_PC = 32'h1C000020; EX_Taken = 1'b1; EX_Target = 32'h1C000777;
    @(posedge clk);
    lookup(32'h1C000020, "no_update");

    // Reset during an update: reset wins, everything invalidated
    @(negedge clk);
    EX_Update = 1'b1; EX_Inst_PC = 32'h1C000030; EX_Taken = 1'b1; EX_Target = 32'h1C000300;
    #1 rstn = 1'b0;
    model_reset();
    score("async_reset");
    @(posedge clk);
    #1 EX_Update = 1'b0;
    @(negedge clk) rstn = 1'b1;
    lookup(32'h1C000030, "reset_discard");
    lookup(32'h1C000050, "reset_cleared");

`ifdef BP_STATS_EN
    @(negedge clk) rstn = 1'b0;
    model_reset();
    #2 rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      EX_Update     = (c < 3);
      EX_Inst_PC    = 32'h1C000010;
      EX_Taken      = (c != 1);
      EX_Target     = 32'h1C000040;
      EX_Mispredict = (c < 2);
      PC            = (c >= 3 && c < 7) ? 32'h1C000010 : 32'h1C000200;
      @(posedge clk);
      if (c < 3) model_update(32'h1C000010, (c != 1), 32'h1C000040);
      #1;
    end
    EX_Update = 1'b0;
    chk("stat_lookups", Stat_Lookups, 32'd10);
    chk("stat_hits", Stat_Hits, 32'd4);
    chk("stat_mispred", Stat_Mispred, 32'd2);
    #1 rstn = 1'b0;
    #1;
    chk("stat_lookups_rst", Stat_Lookups, 32'd0);
    chk("stat_hits_rst", Stat_Hits, 32'd0);
    chk("stat_mispred_rst", Stat_Mispred, 32'd0);
    #10 rstn = 1'b1;
`endif

    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
